pipeline_stall_ctrl: RTL

//   Consumes the stall requests raised by hazard detection and the branch/jump decisions resolved in ID.

---
 rtl/pipeline_stall_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline.
// Mealy control outputs plus a multi-cycle stall counter, saturating statistics and a watchdog.
module pipeline_stall_ctrl #(
  parameter int unsigned STALL_W = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned FLUSH_W = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stall_Req,
  input  logic [STALL_W-1:0] Stall_Len,
  input  logic               Branch_Taken,
  input  logic               Jump,
  input  logic               Mem_Busy,
  output logic               PC_Write,
  output logic               IF_ID_Write,
  output logic               IF_ID_Flush,
  output logic               ID_EX_Write,
  output logic               ID_EX_Bubble,
  output logic               EX_MEM_Write,
  output logic               MEM_WB_Write,
  output logic               Busy,
  output logic [CNT_W-1:0]   Stall_Total,
  output logic [FLUSH_W-1:0] Flush_Total,
  output logic               Timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t               r_state;
  logic [STALL_W-1:0]   r_remain;
  logic [CNT_W-1:0]     r_stall_total;
  logic [FLUSH_W-1:0]   r_flush_total;
  logic [WD_W-1:0]      r_wd;
  logic                 r_timeout;

  logic                 w_stall;
  logic                 w_redirect;
  logic [STALL_W-1:0]   w_len_eff;

  assign w_stall    = (r_state == ST_STALL) || Stall_Req;
  assign w_redirect = Branch_Taken || Jump;
  // A zero-length request still costs one bubble.
  assign w_len_eff  = (Stall_Len == '0) ? STALL_W'(1) : Stall_Len;

  // Control outputs: Reset > Mem_Busy > stall > redirect > normal.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    if (Reset) begin
      PC_Write = 1'b1;
    end else if (Mem_Busy) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (w_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (w_redirect) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  // State, stall counter, statistics and watchdog.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= ST_RUN;
      r_remain      <= '0;
      r_stall_total <= '0;
      r_flush_total <= '0;
      r_wd          <= '0;
      r_timeout     <= 1'b0;
    end else begin
      if (!Mem_Busy) begin
        if (r_state == ST_STALL) begin
          r_remain <= r_remain - STALL_W'(1);
          if (r_remain == STALL_W'(1)) begin
            r_state <= ST_RUN;
          end
        end else if (Stall_Req && (w_len_eff > STALL_W'(1))) begin
          r_state  <= ST_STALL;
          r_remain <= w_len_eff - STALL_W'(1);
        end
      end

      if (ID_EX_Bubble && (r_stall_total != '1)) begin
        r_stall_total <= r_stall_total + CNT_W'(1);
      end
      if (IF_ID_Flush && (r_flush_total != '1)) begin
        r_flush_total <= r_flush_total + FLUSH_W'(1);
      end

      // Watchdog counts consecutive PC-frozen cycles and saturates at TIMEOUT.
      if (!PC_Write) begin
        if (r_wd != WD_W'(TIMEOUT)) begin
          r_wd <= r_wd + WD_W'(1);
        end
        if (r_wd == WD_W'(TIMEOUT - 1)) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_wd <= '0;
      end
    end
  end

  assign Busy        = (r_state == ST_STALL);
  assign Stall_Total = r_stall_total;
  assign Flush_Total = r_flush_total;
  assign Timeout     = r_timeout;

endmodule
